// File: rtl/dec3to8_pulse_gen.sv
// -----------------------------------------------------------------------------
// dec3to8_pulse_gen
//
// Purpose:
//   Accepts a 3-bit code through a valid/ready handshake and drives the
//   registered one-hot decode of that code on y.
//   - Stretch build: y is held for HOLD cycles. It is then followed by GAP
//     idle cycles before the next code is accepted.
//   - Default build: y is a single-cycle pulse and done coincides with it.
//
// Build option:
//   DEC_STRETCH_EN  - when defined, the HOLD/GAP counters are built. When
//                     undefined, HOLD is fixed at 1 and GAP is fixed at 0.
//
// Parameters:
//   HOLD  - drive cycles per accepted code (1..255; 0 behaves as 1).
//   GAP   - forced idle cycles after each drive phase (0..255).
//
// Ports:
//   clk       in   1  clock; all state changes on the rising edge
//   rst_n     in   1  asynchronous active-low reset
//   in_valid  in   1  source presents a code this cycle
//   in_code   in   3  binary index 0..7 to decode
//   in_ready  out  1  high only in IDLE (also high while in reset)
//   y         out  8  registered one-hot decode; zero when not driving
//   busy      out  1  high in DRIVE or GAP
//   done      out  1  high on the last cycle of each drive phase
//   evt_cnt   out  8  accepted-code count, wraps modulo 256
// -----------------------------------------------------------------------------
module dec3to8_pulse_gen #(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic [7:0] y,
  output logic       busy,
  output logic       done,
  output logic [7:0] evt_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Parameters clamped into the range the 8-bit counters can represent.
  // A HOLD of 0 would mean "no drive phase at all", so it is promoted to 1.
  localparam int HOLD_EFF = (HOLD < 1) ? 1 : ((HOLD > 255) ? 255 : HOLD);
  localparam int GAP_EFF  = (GAP < 0) ? 0 : ((GAP > 255) ? 255 : GAP);

  state_t     state_reg, state_next;
  logic [7:0] y_reg, y_next;
  logic [7:0] evt_cnt_reg, evt_cnt_next;
  logic [7:0] code_onehot;
  logic       accept;

  // One comparator per output bit.
  // This guarantees at most one bit of code_onehot is ever set.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_onehot
      assign code_onehot[gi] = (in_code == 3'(gi));
    end
  endgenerate

  // Handshake and status are decoded straight from the state register.
  // Reset therefore forces in_ready=1 and busy=0 without waiting for clk.
  assign in_ready = (state_reg == S_IDLE);
  assign busy     = (state_reg != S_IDLE);
  assign accept   = in_valid && in_ready;

  assign y       = y_reg;
  assign evt_cnt = evt_cnt_reg;

  // Shared state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      y_reg       <= 8'h00;
      evt_cnt_reg <= 8'h00;
    end else begin
      state_reg   <= state_next;
      y_reg       <= y_next;
      evt_cnt_reg <= evt_cnt_next;
    end
  end

`ifdef DEC_STRETCH_EN

  // Counters are loaded with N-1 and count down to zero.
  // The phase therefore lasts exactly N cycles.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_EFF - 1);
  localparam logic [7:0] GAP_LOAD  = (GAP_EFF > 0) ? 8'(GAP_EFF - 1) : 8'd0;
  localparam bit         GAP_ON    = (GAP_EFF > 0);

  logic [7:0] hold_cnt_reg, hold_cnt_next;
  logic [7:0] gap_cnt_reg, gap_cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_reg <= 8'd0;
      gap_cnt_reg  <= 8'd0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    y_next        = y_reg;
    evt_cnt_next  = evt_cnt_reg;
    hold_cnt_next = hold_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          y_next        = code_onehot;
          state_next    = S_DRIVE;
          hold_cnt_next = HOLD_LOAD;
          evt_cnt_next  = evt_cnt_reg + 8'd1;
        end
      end
      S_DRIVE: begin
        if (hold_cnt_reg == 8'd0) begin
          y_next = 8'h00;
          if (GAP_ON) begin
            state_next   = S_GAP;
            gap_cnt_next = GAP_LOAD;
          end else begin
            // A GAP of 0 still passes through one IDLE cycle before the
            // next accept, because in_ready is decoded from IDLE only.
            state_next = S_IDLE;
          end
        end else begin
          hold_cnt_next = hold_cnt_reg - 8'd1;
        end
      end
      S_GAP: begin
        if (gap_cnt_reg == 8'd0) begin
          state_next = S_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - 8'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
        y_next     = 8'h00;
      end
    endcase
  end

  assign done = (state_reg == S_DRIVE) && (hold_cnt_reg == 8'd0);

`else

  // Without the stretch counters, every drive phase is exactly one cycle.
  // GAP is never entered. HOLD/GAP are accepted but have no effect in this
  // build. The empty block below only records that fact.
  if ((HOLD_EFF != 1) || (GAP_EFF != 0)) begin : g_stretch_params_ignored
  end

  always_comb begin
    state_next   = state_reg;
    y_next       = y_reg;
    evt_cnt_next = evt_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          y_next       = code_onehot;
          state_next   = S_DRIVE;
          evt_cnt_next = evt_cnt_reg + 8'd1;
        end
      end
      S_DRIVE: begin
        y_next     = 8'h00;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        y_next     = 8'h00;
      end
    endcase
  end

  assign done = (state_reg == S_DRIVE);

`endif

endmodule

// File: tb/tb_dec3to8_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_dec3to8_pulse_gen
//
// Purpose:
//   Self-checking bench for dec3to8_pulse_gen.
//   - Expected timing follows the build: HOLD=4/GAP=1 with DEC_STRETCH_EN,
//     otherwise HOLD=1/GAP=0.
//   - Inputs are driven on the falling edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_dec3to8_pulse_gen;

  localparam int HOLD = 4;
  localparam int GAP  = 1;
`ifdef DEC_STRETCH_EN
  localparam int EH = HOLD;
  localparam int EG = GAP;
`else
  localparam int EH = 1;
  localparam int EG = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = 3'd0;
  logic       in_ready;
  logic [7:0] y;
  logic       busy;
  logic       done;
  logic [7:0] evt_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_evt = 8'd0;

  typedef struct {
    logic [2:0] code;
    logic [7:0] exp_y;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  dec3to8_pulse_gen #(.HOLD(HOLD), .GAP(GAP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_code  (in_code),
    .in_ready (in_ready),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .evt_cnt  (evt_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One complete transaction, starting from a falling edge with in_ready=1.
  // It returns at the falling edge where IDLE is seen again.
  task automatic run_xfer(input logic [2:0] code, input logic [7:0] exp_y);
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = code;
    @(negedge clk);
    in_valid = 1'b0;
    exp_evt  = exp_evt + 8'd1;
    for (int k = 0; k < EH; k++) begin
      if (k > 0) @(negedge clk);
      check("drive_y", y, exp_y);
      check("drive_done", done, (k == EH - 1));
      check("drive_ready", in_ready, 0);
      check("drive_busy", busy, 1);
    end
    for (int g = 0; g < EG; g++) begin
      @(negedge clk);
      check("gap_y", y, 0);
      check("gap_busy", busy, 1);
      check("gap_done", done, 0);
      check("gap_ready", in_ready, 0);
    end
    @(negedge clk);
    check("idle_ready", in_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_y", y, 0);
    check("evt_cnt", evt_cnt, exp_evt);
    $display("xfer code=%0d y=%02h evt_cnt=%0d", code, exp_y, evt_cnt);
  endtask

  // Bounded wait for IDLE; an expired bound counts as a failure.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      check({name, "_no_code2"}, (y == 8'h04), 0);
      @(negedge clk);
      n++;
    end
    check({name, "_ready"}, in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] one;
    logic [7:0] sweep_start;
    int         n;

    vecs[0] = '{3'd5, 8'h20};
    vecs[1] = '{3'd0, 8'h01};
    vecs[2] = '{3'd7, 8'h80};
    vecs[3] = '{3'd3, 8'h08};
    vecs[4] = '{3'd1, 8'h02};
    vecs[5] = '{3'd6, 8'h40};
    vecs[6] = '{3'd2, 8'h04};
    vecs[7] = '{3'd4, 8'h10};

    // Reset state, sampled while rst_n is still low.
    #12;
    check("rst_y", y, 0);
    check("rst_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_evt", evt_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);

    // Table-driven single transactions; the first is code 5 -> 8'h20.
    for (int i = 0; i < 8; i++) begin
      run_xfer(vecs[i].code, vecs[i].exp_y);
    end

    // Back-to-back sweep with in_valid held high.
    sweep_start = exp_evt;
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_code = 3'(c);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (y == 8'h00 && n < 20);
      one = 8'h01 << c;
      check("sweep_y", y, one);
      exp_evt = exp_evt + 8'd1;
      check("sweep_evt", evt_cnt, exp_evt);
      n = 0;
      while (!in_ready && n < 20) begin
        check("sweep_onehot", $onehot0(y), 1);
        @(negedge clk);
        n++;
      end
      check("sweep_ready", in_ready, 1);
      check("sweep_idle_y", y, 0);
      $display("sweep code=%0d y=%02h evt_cnt=%0d", c, one, evt_cnt);
    end
    in_valid = 1'b0;
    check("sweep_total", evt_cnt, sweep_start + 8'd8);

    // in_valid with code 2 arriving while code 6 is driving is ignored.
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = 3'd6;
    @(negedge clk);
    exp_evt = exp_evt + 8'd1;
    check("ign_first_y", y, 8'h40);
    in_code = 3'd2;
    @(negedge clk);
    in_valid = 1'b0;
    check("ign_y", y, (EH > 1) ? 8'h40 : 8'h00);
    check("ign_evt", evt_cnt, exp_evt);
    wait_ready("ign");
    check("ign_evt_end", evt_cnt, exp_evt);
    $display("ignore code=2 during code=6 evt_cnt=%0d", evt_cnt);

    // Reset during the drive of code 7 (2nd drive cycle when HOLD>1).
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = 3'd7;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_y1", y, 8'h80);
    if (EH > 1) begin
      @(negedge clk);
      check("abort_y2", y, 8'h80);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_evt = 8'd0;
    check("abort_y", y, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", in_ready, 1);
    check("abort_evt", evt_cnt, 0);
    @(posedge clk);
    #1;
    check("abort_hold_y", y, 0);
    check("abort_hold_done", done, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_code  = 3'd3;
    @(negedge clk);
    in_valid = 1'b0;
    exp_evt  = 8'd1;
    check("first_after_rst_y", y, 8'h08);
    check("first_after_rst_evt", evt_cnt, 1);
    wait_ready("after_rst");
    $display("abort code=7 then code=3 evt_cnt=%0d", evt_cnt);

    // Drive the count to 255, then the 256th wraps to 0 and the 257th gives 1.
    n = 0;
    while (exp_evt != 8'hFF) begin
      one = 8'h01 << (n % 8);
      run_xfer(3'(n % 8), one);
      n++;
    end
    run_xfer(3'd0, 8'h01);
    check("wrap_zero", evt_cnt, 0);
    run_xfer(3'd1, 8'h02);
    check("wrap_one", evt_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
